// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer: FSM state
// encoding, register FunSel codes and the Moore output decode.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        WR_LO  = 3'd2,
        REQ_HI = 3'd3,
        WR_HI  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } fetch_state_t;

    // FunSel codes understood by the IR and PC registers.
    localparam logic [2:0] FS_DEC      = 3'b000;
    localparam logic [2:0] FS_INC      = 3'b001;
    localparam logic [2:0] FS_LOAD     = 3'b010;
    localparam logic [2:0] FS_CLR      = 3'b011;
    localparam logic [2:0] FS_CLR_WRLO = 3'b100;
    localparam logic [2:0] FS_WRLO     = 3'b101;
    localparam logic [2:0] FS_WRHI     = 3'b110;
    localparam logic [2:0] FS_SEXT     = 3'b111;

    typedef struct packed {
        logic        mem_req;
        logic        ir_e;
        logic [2:0]  ir_funsel;
        logic [15:0] ir_i;
        logic        pc_e;
        logic [2:0]  pc_funsel;
        logic        busy;
        logic        done;
        logic        error;
    } fetch_outs_t;

    // Moore output values for a given state; byte_val feeds IR_I in write states.
    function automatic fetch_outs_t moore_outputs(input fetch_state_t s,
                                                  input logic [7:0] byte_val);
        fetch_outs_t o;
        // NOTE: every field gets a default before the case, so no path leaves
        // a field unassigned (the same rule that prevents latches in always_comb).
        o = '0;
        case (s)
            REQ_LO, REQ_HI: begin
                o.mem_req = 1'b1;
                o.busy    = 1'b1;
            end
            WR_LO: begin
                o.ir_e      = 1'b1;
                o.ir_funsel = FS_CLR_WRLO;
                o.ir_i      = {8'h00, byte_val};
                o.pc_e      = 1'b1;
                o.pc_funsel = FS_INC;
                o.busy      = 1'b1;
            end
            WR_HI: begin
                o.ir_e      = 1'b1;
                o.ir_funsel = FS_WRHI;
                o.ir_i      = {8'h00, byte_val};
                o.pc_e      = 1'b1;
                o.pc_funsel = FS_INC;
                o.busy      = 1'b1;
            end
            DONE: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            ERR: begin
                o.error = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Byte-wide memory read bus between the fetch sequencer and instruction memory.
interface fetch_sequencer_if;

    logic        MemReq;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        MemAck;

    modport master (
        output MemReq,
        output MemAddr,
        input  MemData,
        input  MemAck
    );

    modport slave (
        input  MemReq,
        input  MemAddr,
        output MemData,
        output MemAck
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acknowledged request cycles and flags when the
// TIMEOUT_CYCLES-th such cycle is in progress.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Cleared outside request states, so each request state starts from zero.
    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // Expiry only while still waiting; an ack in the same cycle drops count_en.
    assign expired = count_en && (count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads the low byte at PC, writes it to
// IR and increments PC, then does the same for the high byte at PC+1.
// Optional feature macro: FETCH_TIMEOUT_EN (aborts a request to ERR after
// TIMEOUT_CYCLES consecutive cycles without MemAck).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [15:0]              PCQ,
    fetch_sequencer_if.master        mem,
    output logic                     IR_E,
    output logic [2:0]               IR_FunSel,
    output logic [15:0]              IR_I,
    output logic                     PC_E,
    output logic [2:0]               PC_FunSel,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Error
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be in 2..255");
    end

    fetch_state_t state;
    fetch_outs_t  outs;
    logic [7:0]   byte_latch;
    logic         timeout;

`ifdef FETCH_TIMEOUT_EN
    logic in_req;

    assign in_req = (state == REQ_LO) || (state == REQ_HI);

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (!in_req),
        .count_en (in_req && !mem.MemAck),
        .expired  (timeout)
    );

    assign Error = outs.error;
`else
    logic unused_error_bit;

    // Requests wait forever, so ERR is never entered and its flag bit is parked.
    assign timeout          = 1'b0;
    assign unused_error_bit = outs.error;
    assign Error            = 1'b0;
`endif

    // FSM: state, byte latch and registered Moore outputs move together.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments only, so every register samples
        // pre-edge values regardless of statement order.
        if (Reset) begin
            state      <= IDLE;
            // NOTE: the byte latch is reset so IR_I never exposes a stale byte.
            byte_latch <= 8'h00;
            outs       <= moore_outputs(IDLE, 8'h00);
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= REQ_LO;
                        outs  <= moore_outputs(REQ_LO, byte_latch);
                    end
                end
                REQ_LO: begin
                    if (mem.MemAck) begin
                        byte_latch <= mem.MemData;
                        state      <= WR_LO;
                        outs       <= moore_outputs(WR_LO, mem.MemData);
                    end else if (timeout) begin
                        state <= ERR;
                        outs  <= moore_outputs(ERR, byte_latch);
                    end
                end
                WR_LO: begin
                    state <= REQ_HI;
                    outs  <= moore_outputs(REQ_HI, byte_latch);
                end
                REQ_HI: begin
                    if (mem.MemAck) begin
                        byte_latch <= mem.MemData;
                        state      <= WR_HI;
                        outs       <= moore_outputs(WR_HI, mem.MemData);
                    end else if (timeout) begin
                        state <= ERR;
                        outs  <= moore_outputs(ERR, byte_latch);
                    end
                end
                WR_HI: begin
                    state <= DONE;
                    outs  <= moore_outputs(DONE, byte_latch);
                end
                DONE: begin
                    state <= IDLE;
                    outs  <= moore_outputs(IDLE, byte_latch);
                end
                ERR: begin
                    if (Start) begin
                        state <= REQ_LO;
                        outs  <= moore_outputs(REQ_LO, byte_latch);
                    end
                end
                default: begin
                    state <= IDLE;
                    outs  <= moore_outputs(IDLE, byte_latch);
                end
            endcase
        end
    end

    // The address follows the live PC only while a byte request is outstanding.
    assign mem.MemReq  = outs.mem_req;
    assign mem.MemAddr = outs.mem_req ? PCQ : 16'h0000;

    assign IR_E      = outs.ir_e;
    assign IR_FunSel = outs.ir_funsel;
    assign IR_I      = outs.ir_i;
    assign PC_E      = outs.pc_e;
    assign PC_FunSel = outs.pc_funsel;
    assign Busy      = outs.busy;
    assign Done      = outs.done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: models the external PC and IR
// registers and predicts the per-cycle output trace of each fetch from the
// fetch rules (request until ack, write, request, write, done).
module tb_fetch_sequencer;

    localparam int T = 16;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] PCQ;
    logic        IR_E;
    logic [2:0]  IR_FunSel;
    logic [15:0] IR_I;
    logic        PC_E;
    logic [2:0]  PC_FunSel;
    logic        Busy;
    logic        Done;
    logic        Error;

    fetch_sequencer_if mem_if ();

    fetch_sequencer #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .PCQ       (PCQ),
        .mem       (mem_if.master),
        .IR_E      (IR_E),
        .IR_FunSel (IR_FunSel),
        .IR_I      (IR_I),
        .PC_E      (PC_E),
        .PC_FunSel (PC_FunSel),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // External PC and IR register models plus event counters.
    logic [15:0] pc_reg;
    logic [15:0] ir_reg;
    logic        pc_load;
    logic [15:0] pc_load_val;
    int          ir_writes  = 0;
    int          done_count = 0;

    assign PCQ = pc_reg;

    // Register models react to the enables the sequencer drives.
    always @(posedge Clock) begin
        if (pc_load)
            pc_reg <= pc_load_val;
        else if (PC_E && PC_FunSel == 3'b001)
            pc_reg <= pc_reg + 16'd1;
        if (IR_E) begin
            ir_writes <= ir_writes + 1;
            if (IR_FunSel == 3'b100)
                ir_reg <= {8'h00, IR_I[7:0]};
            else if (IR_FunSel == 3'b110)
                ir_reg <= {IR_I[7:0], ir_reg[7:0]};
        end
        if (Done)
            done_count <= done_count + 1;
    end

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        ir_e;
        logic [2:0]  ir_fs;
        logic [15:0] ir_i;
        logic        pc_e;
        logic [2:0]  pc_fs;
        logic        busy;
        logic        done;
        logic        err;
        logic        start;
        logic        ack;
        logic [7:0]  data;
    } step_t;

    function automatic step_t quiet();
        step_t s;
        s.req = 1'b0;  s.addr = 16'h0000; s.ir_e = 1'b0; s.ir_fs = 3'b000;
        s.ir_i = 16'h0000; s.pc_e = 1'b0; s.pc_fs = 3'b000; s.busy = 1'b0;
        s.done = 1'b0; s.err = 1'b0; s.start = 1'b0; s.ack = 1'b0; s.data = 8'h00;
        return s;
    endfunction

    function automatic logic [63:0] expect_vec(input step_t s);
        return {20'h0, s.req, s.addr, s.ir_e, s.ir_fs, s.ir_i, s.pc_e, s.pc_fs,
                s.busy, s.done, s.err};
    endfunction

    function automatic logic [63:0] observed();
        return {20'h0, mem_if.MemReq, mem_if.MemAddr, IR_E, IR_FunSel, IR_I,
                PC_E, PC_FunSel, Busy, Done, Error};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic ack, input logic [7:0] d);
        Start          = st;
        mem_if.MemAck  = ack;
        mem_if.MemData = d;
    endtask

    function automatic logic noise_bit(input int noise);
        return (noise == 1) ? 1'($urandom) : 1'b0;
    endfunction

    // One complete fetch from IDLE/ERR. Wait counts are cycles before the ack.
    // noise: 0 none, 1 random Start/stray MemAck, 2 Start in REQ_HI and DONE.
    task automatic run_fetch(input string name, input logic [15:0] pc0,
                             input logic [7:0] lo, input logic [7:0] hi,
                             input int d_lo, input int d_hi, input int noise);
        step_t tr[$];
        step_t s;
        int    first_done;
        int    done0;

        for (int k = 0; k <= d_lo; k++) begin
            s = quiet(); s.req = 1'b1; s.addr = pc0; s.busy = 1'b1;
            s.ack = (k == d_lo); s.data = s.ack ? lo : 8'($urandom);
            s.start = noise_bit(noise);
            tr.push_back(s);
        end
        s = quiet(); s.ir_e = 1'b1; s.ir_fs = 3'b100; s.ir_i = {8'h00, lo};
        s.pc_e = 1'b1; s.pc_fs = 3'b001; s.busy = 1'b1;
        s.start = noise_bit(noise); s.ack = noise_bit(noise); s.data = 8'($urandom);
        tr.push_back(s);
        for (int k = 0; k <= d_hi; k++) begin
            s = quiet(); s.req = 1'b1; s.addr = pc0 + 16'd1; s.busy = 1'b1;
            s.ack = (k == d_hi); s.data = s.ack ? hi : 8'($urandom);
            s.start = (noise == 2) ? 1'b1 : noise_bit(noise);
            tr.push_back(s);
        end
        s = quiet(); s.ir_e = 1'b1; s.ir_fs = 3'b110; s.ir_i = {8'h00, hi};
        s.pc_e = 1'b1; s.pc_fs = 3'b001; s.busy = 1'b1;
        s.start = noise_bit(noise); s.ack = noise_bit(noise); s.data = 8'($urandom);
        tr.push_back(s);
        s = quiet(); s.done = 1'b1; s.busy = 1'b1;
        s.start = (noise == 2) ? 1'b1 : noise_bit(noise);
        s.ack = noise_bit(noise); s.data = 8'($urandom);
        tr.push_back(s);
        for (int k = 0; k < 2; k++) begin
            s = quiet(); s.ack = (noise != 0); s.data = 8'($urandom);
            tr.push_back(s);
        end

        pc_load     = 1'b1;
        pc_load_val = pc0;
        drive(1'b1, 1'b0, 8'h00);
        tick();
        pc_load = 1'b0;
        done0      = done_count;
        first_done = -1;
        foreach (tr[i]) begin
            check($sformatf("%s cyc%0d", name, i + 1), observed(), expect_vec(tr[i]));
            if (Done === 1'b1 && first_done < 0)
                first_done = i + 1;
            drive(tr[i].start, tr[i].ack, tr[i].data);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check({name, " done_cycle"}, 64'(first_done), 64'(d_lo + d_hi + 5));
        check({name, " pc_after"}, 64'(pc_reg), 64'(16'(pc0 + 16'd2)));
        check({name, " ir_after"}, 64'(ir_reg), 64'({hi, lo}));
        check({name, " done_pulses"}, 64'(done_count - done0), 64'd1);
    endtask

    // Bounds the run in case the DUT or bench stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step_t s;
        int    w0;
        int    done0;

        // Reset dominates a simultaneous Start and MemAck.
        Reset       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'h0000;
        drive(1'b1, 1'b1, 8'hA5);
        tick();
        tick();
        check("reset_outputs", observed(), 64'h0);
        Reset   = 1'b0;
        pc_load = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("idle_after_reset", observed(), 64'h0);

        // Zero-wait memory, the reference fetch at 0x0040.
        run_fetch("zero_wait", 16'h0040, 8'h34, 8'h12, 0, 0, 0);
        // Three wait cycles per byte.
        run_fetch("wait3", 16'h1000, 8'($urandom), 8'($urandom), 3, 3, 0);
        // Start during REQ_HI and DONE plus stray acks afterwards.
        run_fetch("start_busy", 16'h2222, 8'($urandom), 8'($urandom), 1, 2, 2);

        // Stray MemAck while idle starts nothing.
        w0 = ir_writes;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 8'($urandom));
            tick();
            check($sformatf("stray_ack_idle%0d", k), observed(), 64'h0);
        end
        drive(1'b0, 1'b0, 8'h00);
        check("stray_ack_no_write", 64'(ir_writes - w0), 64'd0);

        // Randomized fetches with random waits and input noise.
        for (int n = 0; n < 8; n++) begin
            run_fetch($sformatf("rand%0d", n), 16'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1);
        end

        // Reset asserted during the low-byte write cycle.
        pc_load     = 1'b1;
        pc_load_val = 16'h0100;
        drive(1'b1, 1'b0, 8'h00);
        tick();
        pc_load = 1'b0;
        s = quiet(); s.req = 1'b1; s.addr = 16'h0100; s.busy = 1'b1;
        check("midreset_req_lo", observed(), expect_vec(s));
        drive(1'b0, 1'b1, 8'h77);
        tick();
        s = quiet(); s.ir_e = 1'b1; s.ir_fs = 3'b100; s.ir_i = 16'h0077;
        s.pc_e = 1'b1; s.pc_fs = 3'b001; s.busy = 1'b1;
        check("midreset_wr_lo", observed(), expect_vec(s));
        Reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("midreset_after", observed(), 64'h0);
        Reset = 1'b0;
        done0 = done_count;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("midreset_idle%0d", k), observed(), 64'h0);
        end
        check("midreset_no_done", 64'(done_count - done0), 64'd0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: ERR after T request cycles, no IR write, then restart.
        pc_load     = 1'b1;
        pc_load_val = 16'h5000;
        drive(1'b1, 1'b0, 8'h00);
        tick();
        pc_load = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        w0 = ir_writes;
        for (int k = 0; k < T; k++) begin
            s = quiet(); s.req = 1'b1; s.addr = 16'h5000; s.busy = 1'b1;
            check($sformatf("timeout_req%0d", k), observed(), expect_vec(s));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            s = quiet(); s.err = 1'b1;
            check($sformatf("timeout_err%0d", k), observed(), expect_vec(s));
            drive(1'b0, 1'b1, 8'h55);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        check("timeout_no_ir_write", 64'(ir_writes - w0), 64'd0);
        run_fetch("err_restart", 16'h5000, 8'($urandom), 8'($urandom), 1, 2, 0);
        // Ack on the last permitted wait cycle wins over the timeout.
        run_fetch("ack_at_limit", 16'h6000, 8'($urandom), 8'($urandom), T - 1, T - 1, 0);
`else
        // Without the timeout, a long wait still completes and Error stays 0.
        run_fetch("long_wait", 16'h3000, 8'($urandom), 8'($urandom), 40, 20, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 16, SHALL set the consecutive un-acked request cycles before a fetch aborts (range 2..255).
REQ-002: Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: Reset  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-004: Start  input  1  SHALL request one 16-bit instruction fetch; sampled only in IDLE or ERR.
REQ-005: PCQ  input  16  SHALL carry the current Q of the PC register.
REQ-006: MemData  input  8  SHALL carry the byte returned by memory, valid when MemAck=1.
REQ-007: MemAck  input  1  SHALL acknowledge the outstanding byte request.
REQ-008: MemReq  output  1  SHALL request a byte read at MemAddr.
REQ-009: MemAddr  output  16  SHALL equal PCQ while MemReq=1, else 16'h0000.
REQ-010: IR_E, IR_FunSel[2:0], IR_I[15:0]  outputs  SHALL drive the IR register's E/FunSel/I inputs.
REQ-011: PC_E, PC_FunSel[2:0]  outputs  SHALL drive the PC register's E/FunSel inputs.
REQ-012: Busy  output  1  SHALL be 1 in every state except IDLE and ERR.
REQ-013: Done  output  1  SHALL pulse for exactly one cycle when a fetch completes.
REQ-014: Error  output  1  SHALL flag a timed-out fetch.

Function
REQ-015: The FSM SHALL have states IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, DONE, ERR, with Moore outputs.
REQ-016: IDLE: Start=1 -> REQ_LO; otherwise stay.
REQ-017: REQ_LO/REQ_HI: MemReq=1, held until MemAck=1; on MemAck the FSM SHALL capture MemData into an 8-bit byte latch and advance to WR_LO/WR_HI respectively.
REQ-018: WR_LO: IR_E=1, IR_FunSel=100 (clear, write low), IR_I={8'h00, latch}, PC_E=1, PC_FunSel=001 (increment); -> REQ_HI.
REQ-019: WR_HI: IR_E=1, IR_FunSel=110 (write high), IR_I={8'h00, latch}, PC_E=1, PC_FunSel=001; -> DONE.
REQ-020: DONE: Done=1; -> IDLE unconditionally; a Start in DONE SHALL be ignored.
REQ-021: In all states other than WR_LO/WR_HI: IR_E=0, PC_E=0, both FunSel=000, IR_I=16'h0000.
REQ-022: Zero-wait memory (MemAck in first request cycle) SHALL give Done exactly 5 cycles after the edge sampling Start.
REQ-023: Each byte address SHALL be the PCQ seen in its request state, so the high byte is read from original PC+1.
REQ-024: MemAck outside REQ_LO/REQ_HI SHALL be ignored; Start while Busy SHALL be ignored.

Reset
REQ-025: Reset=1 SHALL force IDLE, clear the byte latch and timeout counter, and zero every output on the next edge, including mid-fetch; no IR/PC enable SHALL be asserted in the cycle after Reset.

Configuration
REQ-026: With FETCH_TIMEOUT_EN defined, a counter SHALL count consecutive cycles in REQ_LO/REQ_HI without MemAck, clear on entry to each request state, and on reaching TIMEOUT_CYCLES move to ERR without issuing any IR/PC write.
REQ-027: ERR SHALL hold Error=1 and Busy=0; Start in ERR SHALL clear Error and go to REQ_LO; MemAck on the same cycle as the timeout SHALL win (capture and advance).
REQ-028: Without FETCH_TIMEOUT_EN, requests SHALL wait indefinitely, ERR is unreachable, Error SHALL be tied 0.

Structure
REQ-029: Package fetch_pkg SHALL hold the state enum and FunSel constants FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_CLR_WRLO=100, FS_WRLO=101, FS_WRHI=110, FS_SEXT=111.
REQ-030: The timeout counter SHALL be one sub-module, fetch_timeout_counter, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-031: PCQ=16'h0040, zero-wait memory returns 8'h34 then 8'h12 -> MemAddr 0040 then 0041; IR writes FunSel 100/I=0034 then 110/I=0012; two PC increments; Done at cycle 5.
REQ-032: MemAck delayed 3 cycles per byte -> MemReq held, no enables during waits, Done at cycle 11.
REQ-033: Reset asserted in WR_LO cycle -> next cycle IDLE, IR_E=PC_E=0, Busy=0, Done never pulses.
REQ-034: Start pulsed during REQ_HI and DONE, stray MemAck in IDLE -> no extra fetch, no enables.
REQ-035: FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no MemAck -> ERR after 16 request cycles, Error=1, no IR write; Start then clears Error and refetches.
REQ-036: FETCH_TIMEOUT_EN, MemAck on 16th wait cycle -> byte captured, fetch completes, Error stays 0.
